// File: rtl/lm_writeback_seq.sv
// ---------------------------------------------------------------------------
// lm_writeback_seq
//
// Load-multiple write-back sequencer. On an accepted start it walks the
// register list from the lowest to the highest set bit. For each set bit it
// reads one word from data memory, at consecutive addresses beginning at
// base_addr. It then writes that word into the register file for exactly
// one cycle. The multi-cycle controller drives start and waits for done.
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        1-cycle request, only looked at in IDLE
//   reg_list     bit i set => load Ri (latched on accepted start)
//   base_addr    first memory address (latched on accepted start)
//   mem_rd       memory read request, held for the whole READ stay
//   mem_addr     memory read address
//   mem_data     memory read data, qualified by mem_valid
//   mem_valid    memory read data valid
//   addrC        register-file write index
//   data_write   register-file write data
//   regw         register-file write enable
//   busy         high while in READ or WRITE
//   done         1-cycle completion pulse
//   err          valid with done: the operation aborted on a read timeout
//   pc_wr        valid with done: R7 was written during the operation
//
// All outputs are registered. Each one is loaded on the same edge that
// enters the state it belongs to.
// ---------------------------------------------------------------------------
module lm_writeback_seq #(
    parameter int DW      = 16,
    parameter int NREG    = 8,
    parameter int TIMEOUT = 15,
    localparam int IW     = $clog2(NREG),
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [NREG-1:0] reg_list,
    input  logic [DW-1:0]   base_addr,
    output logic            mem_rd,
    output logic [DW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    input  logic            mem_valid,
    output logic [IW-1:0]   addrC,
    output logic [DW-1:0]   data_write,
    output logic            regw,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            pc_wr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [NREG-1:0] list;      // registers still to be loaded
    logic [DW-1:0]   ptr;       // address of the next memory read
    logic [CW-1:0]   wait_cnt;  // READ cycles spent waiting for mem_valid

    logic [IW-1:0]   nxt;       // lowest set bit of the remaining list
    logic [NREG-1:0] list_rem;  // list with bit nxt removed

    // Priority encoder. Scanning from the top down lets the lowest set bit
    // win. When the list is empty nxt is 0, and nothing uses it then.
    // NOTE: every output of a combinational block gets a default first; without one a path that skips the assignment infers a latch.
    always_comb begin
        nxt      = '0;
        list_rem = list;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (list[i]) begin
                nxt = IW'(i);
            end
        end
        list_rem[nxt] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so that every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            list       <= '0;
            ptr        <= '0;
            wait_cnt   <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            addrC      <= '0;
            data_write <= '0;
            regw       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            pc_wr      <= 1'b0;
        end else begin
            // The write port and done are single-cycle. They return to zero
            // unless the branch below re-asserts them.
            regw       <= 1'b0;
            addrC      <= '0;
            data_write <= '0;
            done       <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        list     <= reg_list;
                        ptr      <= base_addr;
                        wait_cnt <= '0;
                        err      <= 1'b0;
                        pc_wr    <= 1'b0;
                        if (reg_list != '0) begin
                            state    <= READ;
                            mem_rd   <= 1'b1;
                            mem_addr <= base_addr;
                            busy     <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                READ: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (mem_valid) begin
                        // data_write holds the captured word for its WRITE cycle.
                        state      <= WRITE;
                        mem_rd     <= 1'b0;
                        mem_addr   <= '0;
                        regw       <= 1'b1;
                        addrC      <= nxt;
                        data_write <= mem_data;
                        if (nxt == IW'(NREG - 1)) begin
                            pc_wr <= 1'b1;
                        end
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th READ cycle with no data: abort.
                        state    <= DONE;
                        mem_rd   <= 1'b0;
                        mem_addr <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                    end
                end

                WRITE: begin
                    list     <= list_rem;
                    ptr      <= ptr + DW'(1);   // wraps 0xFFFF -> 0x0000
                    wait_cnt <= '0;
                    if (list_rem != '0) begin
                        state    <= READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= ptr + DW'(1);
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm_writeback_seq.sv
// ---------------------------------------------------------------------------
// tb_lm_writeback_seq
//
// Directed bench for lm_writeback_seq. A negedge process acts as the data
// memory: it returns mem_valid after wait_cyc extra READ cycles and serves
// words from rdvals[] in order. The same process logs every register write,
// every read address, and the cycle of the done pulse. Cycle numbers count
// from the start cycle, which is cycle 0.
// ---------------------------------------------------------------------------
module tb_lm_writeback_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  reg_list;
    logic [15:0] base_addr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_valid;
    logic [2:0]  addrC;
    logic [15:0] data_write;
    logic        regw;
    logic        busy;
    logic        done;
    logic        err;
    logic        pc_wr;

    lm_writeback_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .reg_list   (reg_list),
        .base_addr  (base_addr),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid),
        .addrC      (addrC),
        .data_write (data_write),
        .regw       (regw),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pc_wr      (pc_wr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model and monitor state
    logic [15:0] rdvals [16];
    int          wait_cyc;
    int          rd_run, rd_num;
    bit          armed;
    int          cyc, done_cyc, done_cnt;
    logic        done_err, done_pc;
    int          wr_n;
    logic [2:0]  wr_idx [16];
    logic [15:0] wr_dat [16];
    int          rd_starts, rd_cycles, overlap;
    logic [15:0] rd_addr [16];
    logic        prev_rd;

    task automatic clear_log();
        armed     = 1'b0;
        cyc       = 0;
        done_cyc  = -1;
        done_cnt  = 0;
        done_err  = 1'b0;
        done_pc   = 1'b0;
        wr_n      = 0;
        rd_starts = 0;
        rd_cycles = 0;
        overlap   = 0;
        rd_run    = 0;
        rd_num    = 0;
        prev_rd   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (start && !armed) begin
            armed = 1'b1;
            cyc   = 0;
        end else begin
            cyc++;
        end
        if (regw && wr_n < 16) begin
            wr_idx[wr_n] = addrC;
            wr_dat[wr_n] = data_write;
            wr_n++;
        end
        if (mem_rd && !prev_rd && rd_starts < 16) begin
            rd_addr[rd_starts] = mem_addr;
            rd_starts++;
        end
        if (mem_rd) rd_cycles++;
        if (mem_rd && regw) overlap++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
            done_pc  = pc_wr;
            armed    = 1'b0;
        end
        if (mem_rd) begin
            if (rd_run == wait_cyc && rd_num < 16) begin
                mem_valid = 1'b1;
                mem_data  = rdvals[rd_num];
                rd_num++;
            end else begin
                mem_valid = 1'b0;
            end
            rd_run++;
        end else begin
            mem_valid = 1'b0;
            mem_data  = 16'h0;
            rd_run    = 0;
        end
        prev_rd = mem_rd;
    end

    // Pulse start for one cycle. Returns #1 into cycle 1.
    task automatic go(input logic [7:0] l, input logic [15:0] b);
        @(posedge clk); #1;
        clear_log();
        reg_list  = l;
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        reg_list  = '0;
        base_addr = '0;
        mem_valid = 1'b0;
        mem_data  = '0;
        wait_cyc  = 0;
        for (int i = 0; i < 16; i++) rdvals[i] = '0;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {mem_rd, mem_addr, addrC, data_write, regw, busy, done, err, pc_wr}, 32'd0);
        reset = 1'b0;

        // 1: two registers, zero-wait memory
        wait_cyc  = 0;
        rdvals[0] = 16'hAAAA;
        rdvals[1] = 16'hBBBB;
        go(8'h05, 16'h0040);
        check("t1_busy", busy, 1'b1);
        wait_done(50);
        check("t1_done_cyc", done_cyc, 5);
        check("t1_wr_n", wr_n, 2);
        check("t1_w0", {wr_idx[0], wr_dat[0]}, {3'd0, 16'hAAAA});
        check("t1_w1", {wr_idx[1], wr_dat[1]}, {3'd2, 16'hBBBB});
        check("t1_a0", rd_addr[0], 16'h0040);
        check("t1_a1", rd_addr[1], 16'h0041);
        check("t1_flags", {done_err, done_pc}, 2'b00);
        check("t1_overlap", overlap, 0);
        check("t1_idle", {busy, mem_rd, regw}, 3'b000);

        // 2: empty list
        go(8'h00, 16'h1234);
        wait_done(50);
        check("t2_done_cyc", done_cyc, 1);
        check("t2_wr_n", wr_n, 0);
        check("t2_rd", rd_cycles, 0);

        // 3: address wrap and R7
        rdvals[0] = 16'h1111;
        rdvals[1] = 16'h7777;
        go(8'h81, 16'hFFFF);
        wait_done(50);
        check("t3_a0", rd_addr[0], 16'hFFFF);
        check("t3_a1", rd_addr[1], 16'h0000);
        check("t3_w0", {wr_idx[0], wr_dat[0]}, {3'd0, 16'h1111});
        check("t3_w1", {wr_idx[1], wr_dat[1]}, {3'd7, 16'h7777});
        check("t3_flags", {done_err, done_pc}, 2'b01);
        check("t3_done_cyc", done_cyc, 5);

        // 4: memory never answers -> timeout after 15 READ cycles
        wait_cyc = 1000;
        go(8'h02, 16'h0300);
        wait_done(60);
        check("t4_done_cyc", done_cyc, 16);
        check("t4_flags", {done_err, done_pc}, 2'b10);
        check("t4_wr_n", wr_n, 0);
        check("t4_rd", rd_cycles, 15);
        check("t4_err_hold", err, 1'b1);

        // 5: full list, data on the 2nd READ cycle, stray start mid-run
        wait_cyc = 1;
        for (int i = 0; i < 8; i++) rdvals[i] = 16'hC000 + 16'(i);
        go(8'hFF, 16'h0100);
        check("t5_err_clr", err, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reg_list  = 8'h01;
        base_addr = 16'h0999;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        wait_done(100);
        check("t5_done_cyc", done_cyc, 25);
        check("t5_wr_n", wr_n, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_w%0d", i), {wr_idx[i], wr_dat[i]}, {3'(i), 16'hC000 + 16'(i)});
            check($sformatf("t5_a%0d", i), rd_addr[i], 16'h0100 + 16'(i));
        end
        check("t5_done_cnt", done_cnt, 1);
        check("t5_flags", {done_err, done_pc}, 2'b01);
        check("t5_overlap", overlap, 0);

        // 6: reset during the 2nd WRITE cycle, then a clean rerun
        wait_cyc = 0;
        for (int i = 0; i < 4; i++) rdvals[i] = 16'h5000 + 16'(i);
        go(8'h0F, 16'h0200);
        repeat (3) @(posedge clk);
        #1;
        check("t6_in_write", {regw, addrC}, {1'b1, 3'd1});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_rst_outs", {mem_rd, mem_addr, addrC, data_write, regw, busy, done, err, pc_wr}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt, 0);
        check("t6_wr_n", wr_n, 2);
        check("t6_quiet", {busy, mem_rd, regw}, 3'b000);
        go(8'h0F, 16'h0200);
        wait_done(50);
        check("t6b_done_cyc", done_cyc, 9);
        check("t6b_wr_n", wr_n, 4);
        check("t6b_w3", {wr_idx[3], wr_dat[3]}, {3'd3, 16'h5003});
        check("t6b_a3", rd_addr[3], 16'h0203);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
